// File: rtl/gray_decoder_serial.sv
// rtl/gray_decoder_serial.sv - serial Gray-to-binary decoder, one bit per clock MSB first
module gray_decoder_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] g_reg;
    logic [IDX_W-1:0] idx;
    logic             acc;
    logic             bit_res;

    // Running XOR: each resolved bit is the parity of all Gray bits above and at idx.
    assign bit_res = acc ^ g_reg[idx];

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (idx == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            g_reg      <= '0;
            idx        <= '0;
            acc        <= 1'b0;
            binary_out <= '0;
            words_done <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        g_reg <= gray_in;
                        idx   <= IDX_MSB;
                        acc   <= 1'b0;
                    end
                end
                DECODE: begin
                    binary_out[idx] <= bit_res;
                    acc             <= bit_res;
                    idx             <= idx - IDX_W'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        words_done <= words_done + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_decoder_serial.sv
// tb/tb_gray_decoder_serial.sv - scoreboard bench for gray_decoder_serial
module tb_gray_decoder_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  gray_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  binary_out;
    logic        busy;
    logic [15:0] words_done;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [7:0]  binary_out_w;
    logic        busy_w;
    logic [3:0]  words_done_w;

    int          checks = 0;
    int          errors = 0;
    int          cnt    = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    gray_decoder_serial #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
        .binary_out(binary_out), .busy(busy), .words_done(words_done)
    );

    // Narrow-counter instance shares stimulus to observe words_done wrap.
    gray_decoder_serial #(.WIDTH(8), .CNT_W(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .gray_in(gray_in), .out_valid(out_valid_w), .out_ready(out_ready),
        .binary_out(binary_out_w), .busy(busy_w), .words_done(words_done_w)
    );

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cnt   = 0;
        exp_q.delete();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_binary_out", binary_out, 0);
        check("rst_words_done", words_done, 0);
    endtask

    task automatic accept(input logic [7:0] g);
        int n;
        gray_in  = g;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_in_ready", in_ready, 1);
        exp_q.push_back(g2b(g));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit scramble, input bit chk_lat);
        int n;
        n = 0;
        while (!out_valid && n < 24) begin
            if (n == 0) check("busy_decode", busy, 1);
            if (scramble) gray_in = 8'($urandom);
            tick();
            n++;
        end
        check("out_valid_rise", out_valid, 1);
        if (chk_lat) check("latency", n, 8);
        check("done_in_ready", in_ready, 0);
        check("done_busy", busy, 0);
    endtask

    task automatic recv_word();
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        out_ready = 1'b1;
        check("binary_out", binary_out, e);
        tick();
        out_ready = 1'b0;
        cnt++;
        check("words_done", words_done, cnt & 32'hFFFF);
        check("words_done_w", words_done_w, cnt & 32'hF);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [7:0] vecs [5];
        logic [7:0] held;
        vecs[0] = 8'h00; vecs[1] = 8'h01; vecs[2] = 8'h03;
        vecs[3] = 8'h80; vecs[4] = 8'hFF;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = 8'h00;

        do_reset();

        // Abandon a word with reset on its 4th decode edge.
        gray_in  = 8'h7E;
        in_valid = 1'b1;
        check("mid_accept", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        check("mid_in_ready", in_ready, 1);
        check("mid_out_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_binary_out", binary_out, 0);
        check("mid_words_done", words_done, 0);

        accept(8'hC0);
        wait_done(1'b0, 1'b1);
        check("basic_c0", binary_out, 8'h80);
        recv_word();

        for (int i = 0; i < 5; i++) begin
            accept(vecs[i]);
            wait_done(1'b0, 1'b1);
            recv_word();
        end

        do_reset();
        for (int v = 0; v < 256; v++) begin
            held = 8'(v);
            accept(b2g(held));
            wait_done(1'b0, 1'b0);
            check("roundtrip", binary_out, held);
            recv_word();
        end
        check("count_256", words_done, 256);
        check("count_256_w", words_done_w, 0);

        // Backpressure with a competing input word pending.
        accept(8'hA5);
        wait_done(1'b0, 1'b1);
        gray_in  = 8'h55;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_binary_out", binary_out, g2b(8'hA5));
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        recv_word();
        exp_q.push_back(g2b(8'h55));
        tick();
        in_valid = 1'b0;
        check("bp_second_busy", busy, 1);
        wait_done(1'b0, 1'b1);
        recv_word();

        accept(8'h3C);
        wait_done(1'b1, 1'b1);
        check("holdoff_3c", binary_out, 8'h28);
        recv_word();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
